// File: rtl/active_max_pkg.sv
// Shared definitions for the active-maximum reduction sequencer:
// FSM state encoding, default value width and index-width derivation.
package active_max_pkg;

  // Default width of each signed candidate value.
  localparam int DEFAULT_NUMBER_SIZE = 4;

  // Sequencer states: waiting for a first beat, mid-packet, result presented.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Index/count fields must hold values 0..num_entries inclusive.
  function automatic int idx_width(input int num_entries);
    return $clog2(num_entries + 1);
  endfunction

endpackage

// File: rtl/active_max_cell.sv
// Combinational active-maximum cell. Chooses between a "first" and a
// "second" candidate: when first >= second the first survives only if it
// is active; when second is larger it survives only if it is active.
// Ties therefore keep the first (earlier) candidate.
module active_max_cell #(
  parameter int W = 4
) (
  input  logic signed [W-1:0] first_value,
  input  logic                first_active,
  input  logic signed [W-1:0] second_value,
  input  logic                second_active,
  output logic signed [W-1:0] max_value,
  output logic                any_active,
  output logic                sel_first
);

  logic ge;

  // Signed compare and selection between the two candidates.
  always_comb begin
    ge         = (first_value >= second_value);
    sel_first  = ge ? first_active : !second_active;
    max_value  = sel_first ? first_value : second_value;
    any_active = first_active | second_active;
  end

endmodule

// File: rtl/active_max_reduction_sequencer.sv
// Sequential reduction controller: accepts one signed value per beat with
// an activation bit and reduces the packet to its maximum active value,
// time-sharing a single active_max_cell across the beats.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_valid/in_number/in_active/in_last must stay stable until
// accepted. result_valid and the result fields stay stable until the edge
// where result_ready is also high; the source never withdraws valid.
module active_max_reduction_sequencer
  import active_max_pkg::*;
#(
  parameter int NUMBER_SIZE = DEFAULT_NUMBER_SIZE,
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = idx_width(NUM_ENTRIES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [NUMBER_SIZE-1:0] in_number,
  input  logic                          in_active,
  input  logic                          in_last,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic signed [NUMBER_SIZE-1:0] result_max,
  output logic                          result_active,
  output logic [IDX_W-1:0]              result_index,
  output logic [IDX_W-1:0]              result_count,
  output state_e                        dbg_state
);

  // Count value seen while accepting the final allowed beat of a packet.
  localparam logic [IDX_W-1:0] LAST_COUNT = IDX_W'(NUM_ENTRIES - 1);

  state_e                   state_q, state_d;
  logic signed [NUMBER_SIZE-1:0] acc_value_q, acc_value_d;
  logic                     acc_active_q, acc_active_d;
  logic [IDX_W-1:0]         acc_index_q, acc_index_d;
  logic [IDX_W-1:0]         count_q, count_d;
  logic                     load_result;
  logic                     accept;
  logic                     beat_last;

  logic signed [NUMBER_SIZE-1:0] cell_max;
  logic                     cell_any;
  logic                     cell_sel;

  assign in_ready  = !reset && (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state_q;

  // The accumulator is always the "first" operand so ties keep the earlier beat.
  active_max_cell #(
    .W (NUMBER_SIZE)
  ) u_cell (
    .first_value   (acc_value_q),
    .first_active  (acc_active_q),
    .second_value  (in_number),
    .second_active (in_active),
    .max_value     (cell_max),
    .any_active    (cell_any),
    .sel_first     (cell_sel)
  );

  // Next-state and accumulator update logic.
  always_comb begin
    state_d      = state_q;
    acc_value_d  = acc_value_q;
    acc_active_d = acc_active_q;
    acc_index_d  = acc_index_q;
    count_d      = count_q;
    load_result  = 1'b0;
    beat_last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // First beat loads directly; no comparison is needed.
          acc_value_d  = in_number;
          acc_active_d = in_active;
          acc_index_d  = '0;
          count_d      = IDX_W'(1);
          beat_last    = in_last;
          load_result  = in_last;
          state_d      = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_value_d  = cell_max;
          acc_active_d = cell_any;
          acc_index_d  = cell_sel ? acc_index_q : count_q;
          count_d      = count_q + IDX_W'(1);
          // Forced termination once the packet reaches NUM_ENTRIES beats.
          beat_last    = in_last || (count_q == LAST_COUNT);
          load_result  = beat_last;
          state_d      = beat_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator and beat-count registers; reset discards any partial packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_value_q  <= '0;
      acc_active_q <= 1'b0;
      acc_index_q  <= '0;
      count_q      <= '0;
    end else begin
      acc_value_q  <= acc_value_d;
      acc_active_q <= acc_active_d;
      acc_index_q  <= acc_index_d;
      count_q      <= count_d;
    end
  end

  // Result registers: loaded only on entry to HOLD, cleared valid on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid  <= 1'b0;
      result_max    <= '0;
      result_active <= 1'b0;
      result_index  <= '0;
      result_count  <= '0;
    end else if (load_result) begin
      result_valid  <= 1'b1;
      result_max    <= acc_value_d;
      result_active <= acc_active_d;
      result_index  <= acc_index_d;
      result_count  <= count_d;
    end else if ((state_q == HOLD) && result_ready) begin
      result_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_active_max_reduction_sequencer.sv
// Self-checking bench for active_max_reduction_sequencer: table vectors,
// hand-written hold/forced-termination/reset sequences and random traffic
// against a packet-level reference model.
module tb_active_max_reduction_sequencer;
  import active_max_pkg::*;

  localparam int NS          = 4;
  localparam int NUM_ENTRIES = 8;
  localparam int IDX_W       = 4;
  localparam int RES_W       = NS + 1 + IDX_W + IDX_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NS-1:0]    in_number = '0;
  logic             in_active = 1'b0;
  logic             in_last = 1'b0;
  logic             result_valid;
  logic             rr = 1'b0;
  logic [NS-1:0]    result_max;
  logic             result_active;
  logic [IDX_W-1:0] result_index;
  logic [IDX_W-1:0] result_count;
  state_e           dbg_state;

  active_max_reduction_sequencer #(
    .NUMBER_SIZE (NS),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_number     (in_number),
    .in_active     (in_active),
    .in_last       (in_last),
    .result_valid  (result_valid),
    .result_ready  (rr),
    .result_max    (result_max),
    .result_active (result_active),
    .result_index  (result_index),
    .result_count  (result_count),
    .dbg_state     (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic rand_mode = 1'b0;
  logic last_acc  = 1'b0;
  logic held_prev = 1'b0;
  logic [RES_W-1:0] held_snap = '0;

  typedef struct {
    logic [NS-1:0] v;
    logic          a;
  } beat_t;

  beat_t            pkt[$];
  logic [RES_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: reduce a whole packet by the selection rule (ties keep earlier).
  function automatic logic [RES_W-1:0] reduce_pkt();
    logic signed [NS-1:0] best_v;
    int                   best_i;
    logic                 any_a;
    logic                 keep;
    best_v = $signed(pkt[0].v);
    best_i = 0;
    any_a  = pkt[0].a;
    for (int i = 1; i < pkt.size(); i++) begin
      keep = (best_v >= $signed(pkt[i].v)) ? any_a : !pkt[i].a;
      if (!keep) begin
        best_v = $signed(pkt[i].v);
        best_i = i;
      end
      any_a = any_a | pkt[i].a;
    end
    return {best_v, any_a, IDX_W'(best_i), IDX_W'(pkt.size())};
  endfunction

  task automatic model_accept();
    beat_t b;
    b.v = in_number;
    b.a = in_active;
    pkt.push_back(b);
    if (in_last || (pkt.size() == NUM_ENTRIES)) begin
      exp_q.push_back(reduce_pkt());
      pkt.delete();
    end
  endtask

  // One clock: observe at negedge (scoreboard + model), return #1 after posedge.
  task automatic tick();
    logic [RES_W-1:0] got;
    logic [RES_W-1:0] exp;
    @(negedge clk);
    last_acc = 1'b0;
    if (reset) begin
      pkt.delete();
      exp_q.delete();
      held_prev = 1'b0;
    end else begin
      got = {result_max, result_active, result_index, result_count};
      if (result_valid && held_prev) chk("hold_stable", 32'(got), 32'(held_snap));
      if (result_valid && rr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got=%0h exp=none", got);
        end else begin
          exp = exp_q.pop_front();
          chk("result", 32'(got), 32'(exp));
        end
      end
      held_prev = result_valid && !rr;
      held_snap = got;
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        model_accept();
      end
    end
    @(posedge clk);
    #1;
    if (rand_mode) rr = 1'($urandom_range(0, 1));
  endtask

  // Drive one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [NS-1:0] v, input logic a, input logic l);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    in_number = v;
    in_active = a;
    in_last   = l;
    last_acc  = 1'b0;
    while (!last_acc && guard < 64) begin
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=none exp=accept at %0t", $time);
    end
  endtask

  task automatic take_result();
    rr = 1'b1;
    tick();
    rr = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int            n;
    logic [NS-1:0] v[4];
    logic          a[4];
    logic [NS-1:0] e_max;
    logic          e_act;
    logic [3:0]    e_idx;
    logic [3:0]    e_cnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [NS-1:0] fvals[8];

    vecs[0].n = 4; vecs[0].v = '{4'd3, 4'hE, 4'd5, 4'd1}; vecs[0].a = '{1'b1, 1'b1, 1'b1, 1'b1};
    vecs[0].e_max = 4'd5; vecs[0].e_act = 1'b1; vecs[0].e_idx = 4'd2; vecs[0].e_cnt = 4'd4;
    vecs[1].n = 4; vecs[1].v = '{4'd7, 4'h8, 4'd2, 4'hF}; vecs[1].a = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1].e_max = 4'hF; vecs[1].e_act = 1'b1; vecs[1].e_idx = 4'd3; vecs[1].e_cnt = 4'd4;
    vecs[2].n = 2; vecs[2].v = '{4'd4, 4'd4, 4'd0, 4'd0}; vecs[2].a = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2].e_max = 4'd4; vecs[2].e_act = 1'b1; vecs[2].e_idx = 4'd0; vecs[2].e_cnt = 4'd2;
    vecs[3].n = 2; vecs[3].v = '{4'd1, 4'd6, 4'd0, 4'd0}; vecs[3].a = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3].e_max = 4'd1; vecs[3].e_act = 1'b0; vecs[3].e_idx = 4'd0; vecs[3].e_cnt = 4'd2;

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_outputs", 32'({result_max, result_active, result_index, result_count}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven packets.
    for (int t = 0; t < 4; t++) begin
      rr = 1'b0;
      for (int i = 0; i < vecs[t].n; i++) begin
        send_beat(vecs[t].v[i], vecs[t].a[i], (i == vecs[t].n - 1));
        if (i < vecs[t].n - 1) chk($sformatf("v%0d_early_valid", t), 32'(result_valid), 32'd0);
      end
      chk($sformatf("v%0d_valid", t), 32'(result_valid), 32'd1);
      chk($sformatf("v%0d_max", t), 32'(result_max), 32'(vecs[t].e_max));
      chk($sformatf("v%0d_active", t), 32'(result_active), 32'(vecs[t].e_act));
      chk($sformatf("v%0d_index", t), 32'(result_index), 32'(vecs[t].e_idx));
      chk($sformatf("v%0d_count", t), 32'(result_count), 32'(vecs[t].e_cnt));
      take_result();
    end

    // Held result with back-pressure: no beat consumed while holding.
    send_beat(4'd2, 1'b1, 1'b0);
    send_beat(4'd3, 1'b1, 1'b1);
    in_valid = 1'b1; in_number = 4'd5; in_active = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_no_accept", 32'(last_acc), 32'd0);
      chk("hold_max", 32'(result_max), 32'd3);
    end
    rr = 1'b1;
    tick();
    rr = 1'b0;
    chk("hs_valid_low", 32'(result_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("after_hs_accept", 32'(last_acc), 32'd1);
    chk("after_hs_result", 32'({result_valid, result_max, result_index, result_count}),
        32'({1'b1, 4'd5, 4'd0, 4'd1}));
    take_result();

    // Forced termination after NUM_ENTRIES beats without in_last.
    fvals = '{4'd1, 4'd2, 4'd6, 4'd3, 4'd6, 4'd0, 4'hD, 4'd5};
    rr = 1'b1;
    for (int k = 0; k < NUM_ENTRIES; k++) send_beat(fvals[k], 1'b1, 1'b0);
    chk("forced_valid", 32'(result_valid), 32'd1);
    chk("forced_count", 32'(result_count), 32'd8);
    chk("forced_index", 32'(result_index), 32'd2);
    send_beat(4'd7, 1'b1, 1'b0);
    send_beat(4'd2, 1'b1, 1'b1);
    chk("ninth_beat_packet", 32'({result_valid, result_max, result_index, result_count}),
        32'({1'b1, 4'd7, 4'd0, 4'd2}));
    tick();
    rr = 1'b0;

    // Reset mid-packet discards the partial packet.
    send_beat(4'd3, 1'b1, 1'b0);
    send_beat(4'd1, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    chk("midrst_outputs", 32'({result_valid, result_max, result_active, result_index, result_count}), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    send_beat(4'd6, 1'b1, 1'b0);
    send_beat(4'd2, 1'b1, 1'b1);
    chk("midrst_next", 32'({result_max, result_index, result_count}), 32'({4'd6, 4'd0, 4'd2}));
    take_result();

    // Random traffic against the reference model.
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send_beat(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end
    rand_mode = 1'b0;
    rr = 1'b1;
    send_beat(4'd0, 1'b1, 1'b1);
    for (int d = 0; d < 10 && exp_q.size() != 0; d++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
